// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory request/response, redirect input and the
// valid/ready handshake toward decode. The fetch unit is the master side.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] instruction_code;
  logic [31:0] if_pc;

  modport master (
    output imem_req, imem_addr, if_valid, instruction_code, if_pc,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );

  modport slave (
    input  imem_req, imem_addr, if_valid, instruction_code, if_pc,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, if_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, keeps at most one word request outstanding, buffers
// returned words in a 2-entry FIFO toward decode and discards responses made stale by a
// branch/jump redirect.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2  // only 2 is supported
) (
  input logic                clk,
  input logic                rst_n,
  instr_fetch_unit_if.master io_bus
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StReq  = 2'd1;
  localparam logic [1:0] StWait = 2'd2;

  logic [1:0]  r_state, w_state_nxt;
  logic [31:0] r_pc, w_pc_nxt;
  logic [31:0] r_req_pc, w_req_pc_nxt;
  logic        r_drop, w_drop_nxt;
  logic [1:0]  r_count, w_count_nxt;
  logic        r_head, w_head_nxt;
  logic [31:0] r_buf_instr [2];
  logic [31:0] r_buf_pc    [2];

  logic w_issue;
  logic w_rsp;
  logic w_push;
  logic w_pop;
  logic w_tail;

  // Credit check: only request when the returning word is guaranteed a free slot.
  assign io_bus.imem_req  = (r_state == StReq) && (32'(r_count) < BUF_DEPTH);
  assign io_bus.imem_addr = r_pc;

  assign w_issue = io_bus.imem_req & io_bus.imem_gnt;
  assign w_rsp   = (r_state == StWait) & io_bus.imem_rvalid;
  // A redirect in the response cycle makes that word stale as well.
  assign w_push  = w_rsp & ~r_drop & ~io_bus.redirect_valid;
  assign w_pop   = io_bus.if_valid & io_bus.if_ready;
  // Tail slot = head + count (mod 2).
  assign w_tail  = r_head ^ r_count[0];

  assign io_bus.if_valid         = (r_count != 2'd0);
  assign io_bus.instruction_code = io_bus.if_valid ? r_buf_instr[r_head] : 32'h0;
  assign io_bus.if_pc            = io_bus.if_valid ? r_buf_pc[r_head] : 32'h0;

  // Fetch FSM next state; a redirect overrides every normal update.
  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_req_pc_nxt = r_req_pc;
    w_drop_nxt   = r_drop;
    case (r_state)
      StIdle: w_state_nxt = StReq;
      StReq: begin
        if (w_issue) begin
          w_req_pc_nxt = r_pc;
          w_pc_nxt     = r_pc + 32'd4;
          w_state_nxt  = StWait;
        end
      end
      StWait: begin
        if (io_bus.imem_rvalid) begin
          w_drop_nxt  = 1'b0;
          w_state_nxt = StReq;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
    if (io_bus.redirect_valid) begin
      w_pc_nxt = {io_bus.redirect_pc[31:2], 2'b00};
      // A request still in flight after this cycle must have its response swallowed.
      if (((r_state == StWait) && !io_bus.imem_rvalid) || w_issue) begin
        w_state_nxt = StWait;
        w_drop_nxt  = 1'b1;
      end else begin
        w_state_nxt = StReq;
        w_drop_nxt  = 1'b0;
      end
    end
  end

  // Buffer occupancy; a transfer in the redirect cycle still completes, the rest is flushed.
  always_comb begin
    w_count_nxt = r_count;
    w_head_nxt  = r_head;
    if (io_bus.redirect_valid) begin
      w_count_nxt = 2'd0;
      w_head_nxt  = 1'b0;
    end else begin
      w_count_nxt = r_count + {1'b0, w_push} - {1'b0, w_pop};
      w_head_nxt  = w_pop ? ~r_head : r_head;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= StIdle;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
      r_drop   <= 1'b0;
      r_count  <= 2'd0;
      r_head   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_req_pc <= w_req_pc_nxt;
      r_drop   <= w_drop_nxt;
      r_count  <= w_count_nxt;
      r_head   <= w_head_nxt;
    end
  end

  // Buffer storage: write the returned word and its PC into the tail slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf_instr[0] <= 32'h0;
      r_buf_instr[1] <= 32'h0;
      r_buf_pc[0]    <= 32'h0;
      r_buf_pc[1]    <= 32'h0;
    end else if (w_push) begin
      r_buf_instr[w_tail] <= io_bus.imem_rdata;
      r_buf_pc[w_tail]    <= r_req_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model with grant budget and programmable
// latency, scoreboard of expected (pc, word) pairs popped by a decode-side monitor.
module tb_instr_fetch_unit;

  logic clk;
  logic rst_n;

  instr_fetch_unit_if bus ();

  instr_fetch_unit #(
    .RESET_PC (32'h0000_0000),
    .BUF_DEPTH(2)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io_bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int n_delivered = 0;

  logic [31:0] q_exp [$];   // expected if_pc sequence toward decode
  logic [31:0] q_addr [$];  // expected fetch address sequence toward memory

  int m_total = 0;    // grants allowed so far (stimulus)
  int m_granted = 0;  // grants given so far (memory model)
  int m_lat = 1;      // cycles from grant to rvalid

  assign bus.imem_gnt = (m_granted < m_total);

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'h1357_00AB;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wait_delivered(input int target);
    for (int i = 0; i < 200 && n_delivered < target; i++) cyc(1);
    chk("delivered_count", 32'(n_delivered), 32'(target));
  endtask

  task automatic expect_fetch(input logic [31:0] a, input bit delivered);
    q_addr.push_back(a);
    if (delivered) q_exp.push_back(a);
    m_total++;
  endtask

  // Instruction memory: observes issue before the edge, answers m_lat cycles later.
  initial begin
    logic        m_issue;
    logic [31:0] m_addr;
    logic [31:0] m_pend;
    int          m_cnt;
    m_cnt = 0;
    m_pend = 32'h0;
    bus.imem_rvalid = 1'b0;
    bus.imem_rdata  = 32'h0;
    forever begin
      @(negedge clk);
      m_issue = rst_n & bus.imem_req & bus.imem_gnt;
      m_addr  = bus.imem_addr;
      @(posedge clk);
      #1;
      bus.imem_rvalid = 1'b0;
      if (m_issue) begin
        m_granted++;
        chk("one_outstanding", 32'(m_cnt), 32'd0);
        if (q_addr.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL fetch_addr: unplanned fetch at 0x%08h, want none", m_addr);
        end else begin
          chk("fetch_addr", m_addr, q_addr.pop_front());
        end
        m_pend = m_addr;
        m_cnt  = m_lat;
      end
      if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          bus.imem_rvalid = 1'b1;
          bus.imem_rdata  = word_of(m_pend);
        end
      end
    end
  end

  // Decode-side monitor: every transfer must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.if_valid) begin
        if (bus.if_ready) begin
          n_delivered++;
          if (q_exp.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL if_transfer: unexpected pc 0x%08h, want none", bus.if_pc);
          end else begin
            logic [31:0] e;
            e = q_exp.pop_front();
            chk("if_pc", bus.if_pc, e);
            chk("instruction_code", bus.instruction_code, word_of(e));
          end
        end
      end else begin
        chk("empty_outputs", bus.instruction_code | bus.if_pc, 32'h0);
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    bus.if_ready = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = 32'h0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("rst_imem_addr", bus.imem_addr, 32'h0);
    chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("rst_instruction_code", bus.instruction_code, 32'h0);
    chk("rst_if_pc", bus.if_pc, 32'h0);

    // Streaming: gnt available, 1-cycle latency, decode always ready.
    cyc(2);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) expect_fetch(32'(i * 4), 1'b1);
    cyc(1);
    chk("idle_to_req", 32'(bus.imem_req), 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0);
    wait_delivered(6);

    // Decode stalls: buffer fills to two and requests stop.
    bus.if_ready = 1'b0;
    for (int i = 0; i < 4; i++) expect_fetch(32'h18 + 32'(i * 4), 1'b1);
    cyc(10);
    chk("full_imem_req", 32'(bus.imem_req), 32'd0);
    chk("full_if_valid", 32'(bus.if_valid), 32'd1);
    chk("full_head_pc", bus.if_pc, 32'h18);
    bus.if_ready = 1'b1;
    cyc(1);
    chk("second_entry_valid", 32'(bus.if_valid), 32'd1);
    chk("second_entry_pc", bus.if_pc, 32'h1C);
    wait_delivered(10);

    // Redirect while WAIT with one word buffered; response arrives 3 cycles after grant.
    bus.if_ready = 1'b0;
    expect_fetch(32'h28, 1'b0);
    cyc(6);
    chk("pre_redirect_pc", bus.if_pc, 32'h28);
    m_lat = 3;
    expect_fetch(32'h2C, 1'b0);
    cyc(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_1002;
    cyc(1);
    bus.redirect_valid = 1'b0;
    chk("flush_if_valid", 32'(bus.if_valid), 32'd0);
    chk("redir_wait_req", 32'(bus.imem_req), 32'd0);
    chk("redir_addr", bus.imem_addr, 32'h1000);
    bus.if_ready = 1'b1;
    m_lat = 1;
    expect_fetch(32'h1000, 1'b1);
    expect_fetch(32'h1004, 1'b1);
    wait_delivered(12);

    // Redirect in the grant cycle, then in the response cycle.
    expect_fetch(32'h1008, 1'b0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_2000;
    cyc(1);
    bus.redirect_valid = 1'b0;
    chk("gnt_redir_addr", bus.imem_addr, 32'h2000);
    chk("gnt_redir_req", 32'(bus.imem_req), 32'd0);
    cyc(1);
    chk("gnt_redir_req_back", 32'(bus.imem_req), 32'd1);
    chk("gnt_redir_if_valid", 32'(bus.if_valid), 32'd0);
    expect_fetch(32'h2000, 1'b0);
    cyc(1);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'h0000_3000;
    cyc(1);
    bus.redirect_valid = 1'b0;
    chk("rsp_redir_req", 32'(bus.imem_req), 32'd1);
    chk("rsp_redir_addr", bus.imem_addr, 32'h3000);
    chk("rsp_redir_if_valid", 32'(bus.if_valid), 32'd0);
    expect_fetch(32'h3000, 1'b1);
    expect_fetch(32'h3004, 1'b1);
    wait_delivered(14);

    // Grant withheld: request and address held stable.
    for (int i = 0; i < 5; i++) begin
      cyc(1);
      chk("hold_req", 32'(bus.imem_req), 32'd1);
      chk("hold_addr", bus.imem_addr, 32'h3008);
    end

    // Withdrawn request, low address bits ignored, PC wraps past 0xFFFF_FFFC.
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 32'hFFFF_FFFE;
    cyc(1);
    bus.redirect_valid = 1'b0;
    chk("wrap_start_addr", bus.imem_addr, 32'hFFFF_FFFC);
    chk("wrap_start_req", 32'(bus.imem_req), 32'd1);
    expect_fetch(32'hFFFF_FFFC, 1'b1);
    expect_fetch(32'h0000_0000, 1'b1);
    wait_delivered(16);

    // Reset asserted mid-WAIT; the late response must be ignored.
    m_lat = 3;
    expect_fetch(32'h4, 1'b0);
    cyc(1);
    rst_n = 1'b0;
    #1;
    chk("midrst_imem_req", 32'(bus.imem_req), 32'd0);
    chk("midrst_imem_addr", bus.imem_addr, 32'h0);
    chk("midrst_if_valid", 32'(bus.if_valid), 32'd0);
    chk("midrst_outputs", bus.instruction_code | bus.if_pc, 32'h0);
    cyc(1);
    rst_n = 1'b1;
    m_lat = 1;
    expect_fetch(32'h0, 1'b1);
    cyc(1);
    chk("post_rst_req", 32'(bus.imem_req), 32'd1);
    chk("post_rst_addr", bus.imem_addr, 32'h0);
    wait_delivered(17);

    cyc(5);
    chk("scoreboard_drained", 32'(q_exp.size()), 32'd0);
    chk("fetch_list_drained", 32'(q_addr.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
